// File: rtl/debounce_pkg.sv
// Shared types and limits for the debounce_feed input conditioner.
package debounce_pkg;

  localparam int MIN_SYNC_STAGES   = 2;
  localparam int MIN_STABLE_CYCLES = 2;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_t;

  function automatic logic is_check(input state_t st);
    return (st == CHECK_HI) || (st == CHECK_LO);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchroniser for a single asynchronous bit; clears to 0 on reset.
module sync_chain
  import debounce_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $fatal(1, "sync_chain: STAGES must be at least 2");
  end

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/debounce_feed.sv
// Synchronises and debounces a raw input, producing a clean level d and a
// one-cycle gate strobe en for a downstream level-sensitive latch.
module debounce_feed
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int GLITCH_W      = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                din,
  input  logic                freeze,
  output logic                d,
  output logic                en,
  output logic                busy,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  if (SYNC_STAGES < MIN_SYNC_STAGES) begin : g_bad_sync
    $fatal(1, "debounce_feed: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < MIN_STABLE_CYCLES) begin : g_bad_stable
    $fatal(1, "debounce_feed: STABLE_CYCLES must be at least 2");
  end

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

  function automatic logic [GLITCH_W-1:0] sat_inc(input logic [GLITCH_W-1:0] v);
    return (&v) ? v : v + GLITCH_W'(1);
  endfunction

  logic s;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (din),
    .dout (s)
  );

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                d_q, d_d;
  logic                en_q, en_d;
  logic                busy_q, busy_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    d_d      = d_q;
    en_d     = 1'b0;
    glitch_d = glitch_q;
    unique case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = CHECK_HI;
          cnt_d   = CW'(1);
        end
      end
      CHECK_HI: begin
        if (!s) begin
          state_d  = STABLE_LO;
          cnt_d    = '0;
          glitch_d = sat_inc(glitch_q);
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!freeze) begin
          state_d = STABLE_HI;
          d_d     = 1'b1;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = CHECK_LO;
          cnt_d   = CW'(1);
        end
      end
      CHECK_LO: begin
        if (s) begin
          state_d  = STABLE_HI;
          cnt_d    = '0;
          glitch_d = sat_inc(glitch_q);
        end else if (cnt_q < CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else if (!freeze) begin
          state_d = STABLE_LO;
          d_d     = 1'b0;
          en_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
    // busy is registered from the next state so it lines up with the FSM
    busy_d = is_check(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      d_q      <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      glitch_q <= glitch_d;
    end
  end

  assign d          = d_q;
  assign en         = en_q;
  assign busy       = busy_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: tb/tb_debounce_feed.sv
// Directed bench for debounce_feed with SYNC_STAGES=2, STABLE_CYCLES=4, GLITCH_W=3.
module tb_debounce_feed;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din;
  logic       freeze;
  logic       d;
  logic       en;
  logic       busy;
  logic [2:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;

  debounce_feed #(
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(4),
    .GLITCH_W     (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .freeze    (freeze),
    .d         (d),
    .en        (en),
    .busy      (busy),
    .glitch_cnt(glitch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       din;
    logic       frz;
    logic       d;
    logic       en;
    logic       busy;
    logic [2:0] g;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ed, input logic een,
                         input logic eb, input logic [2:0] eg);
    chk({tag, ".d"},    int'(d),          int'(ed));
    chk({tag, ".en"},   int'(en),         int'(een));
    chk({tag, ".busy"}, int'(busy),       int'(eb));
    chk({tag, ".glit"}, int'(glitch_cnt), int'(eg));
  endtask

  // Async reset: assert away from the edge, outputs must clear at once.
  task automatic do_reset(input int hold_cycles);
    rst_n = 1'b0;
    #1;
    chk_all("reset_now", 1'b0, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < hold_cycles; i++) begin
      tick();
      chk({"reset_hold.en"}, int'(en), 0);
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // clean rise, hold, clean fall, then a two-cycle bounce
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
    vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};

    rst_n  = 1'b1;
    din    = 1'b0;
    freeze = 1'b0;
    #2;
    do_reset(2);
    repeat (3) tick();
    chk_all("idle", 1'b0, 1'b0, 1'b0, 3'd0);

    // Table: row k's inputs are sampled at edge k, outputs checked just after it.
    for (int k = 0; k < 22; k++) begin
      din    = vecs[k].din;
      freeze = vecs[k].frz;
      tick();
      chk_all($sformatf("vec%0d", k), vecs[k].d, vecs[k].en, vecs[k].busy, vecs[k].g);
    end

    // Saturation: nine one-cycle glitches, counter sticks at 7.
    do_reset(1);
    din = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      din = 1'b1;
      tick();
      din = 1'b0;
      repeat (4) tick();
      chk($sformatf("sat%0d.glit", i), int'(glitch_cnt), (i + 1 > 7) ? 7 : i + 1);
      chk($sformatf("sat%0d.d", i), int'(d), 0);
    end

    // Freeze holds a qualified rise until released.
    do_reset(1);
    freeze = 1'b1;
    din    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("frz%0d.d", i), int'(d), 0);
      chk($sformatf("frz%0d.en", i), int'(en), 0);
    end
    chk("frz_end.busy", int'(busy), 1);
    freeze = 1'b0;
    tick();
    chk_all("frz_release", 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    chk_all("frz_after", 1'b1, 1'b0, 1'b0, 3'd0);

    // Revert while frozen aborts as a glitch; d is untouched.
    freeze = 1'b1;
    din    = 1'b0;
    repeat (8) tick();
    chk_all("frzfall_held", 1'b1, 1'b0, 1'b1, 3'd0);
    din = 1'b1;
    repeat (2) tick();
    chk("frzabort_pre.busy", int'(busy), 1);
    tick();
    chk_all("frzabort", 1'b1, 1'b0, 1'b0, 3'd1);
    freeze = 1'b0;
    repeat (3) tick();
    chk_all("frzabort_settle", 1'b1, 1'b0, 1'b0, 3'd1);

    // Reset mid-qualification, then requalify from STABLE_LO with din high.
    do_reset(1);
    din = 1'b1;
    repeat (4) tick();
    chk("midrst_pre.busy", int'(busy), 1);
    do_reset(2);
    for (int k = 0; k < 7; k++) begin
      tick();
      chk($sformatf("postrst%0d.d", k), int'(d), (k == 6) ? 1 : 0);
      chk($sformatf("postrst%0d.en", k), int'(en), (k == 6) ? 1 : 0);
    end
    tick();
    chk_all("postrst_done", 1'b1, 1'b0, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
